// File: rtl/key_pkg.sv
// Shared definitions for the front-panel key shift/load register.
package key_pkg;

  // Operation codes reported on last_op.
  typedef enum logic [1:0] {
    OP_CLR  = 2'd0,
    OP_LOAD = 2'd1,
    OP_SHR  = 2'd2,
    OP_SHL  = 2'd3
  } op_e;

endpackage

// File: rtl/key_debounce.sv
// One push-button front end: 2-flop synchroniser, stability-count debouncer
// and press-edge detector producing a single-cycle press event.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);

  // The counter only ever holds 0..DEBOUNCE_CYCLES-1; reaching the last
  // value with the level still different accepts the change.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Everything below works in "1 = pressed" polarity, so the released
  // level is always 0 regardless of how the board wires the key.
  logic             key_act;
  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic [CNT_W-1:0] cnt;

  assign key_act = KEY_ACTIVE_LOW ? ~key_raw : key_raw;

  // Synchronise, debounce and flag released->pressed transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= key_act;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_p1;
        cnt   <= '0;
        press <= sync_p1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_shift_reg.sv
// Front-panel shift/load register: four debounced buttons clear, load,
// shift right or shift left a data register; shifted-out bits are kept
// in a trace register.
module key_shift_reg
  import key_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       key_clr,
  input  logic                       key_load,
  input  logic                       key_shr,
  input  logic                       key_shl,
  input  logic                       en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       ser_in,
  output logic [WIDTH-1:0]           data_q,
  output logic [WIDTH-1:0]           trace_q,
  output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
  output logic                       full,
  output logic                       op_valid,
  output logic [1:0]                 last_op
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic             ev_clr;
  logic             ev_load;
  logic             ev_shr;
  logic             ev_shl;
  logic             apply;
  op_e              op_nxt;
  op_e              op_q;
  logic [WIDTH-1:0] data_nxt;
  logic [WIDTH-1:0] trace_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW))
    u_db_clr  (.clk(clk), .rst_n(rst_n), .key_raw(key_clr),  .press(ev_clr));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW))
    u_db_load (.clk(clk), .rst_n(rst_n), .key_raw(key_load), .press(ev_load));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW))
    u_db_shr  (.clk(clk), .rst_n(rst_n), .key_raw(key_shr),  .press(ev_shr));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW))
    u_db_shl  (.clk(clk), .rst_n(rst_n), .key_raw(key_shl),  .press(ev_shl));

  // Shift count saturates at WIDTH; shifting itself carries on.
  assign cnt_inc = (shift_cnt == CNT_MAX) ? shift_cnt : shift_cnt + CNT_W'(1);
  assign full    = (shift_cnt == CNT_MAX);
  assign last_op = op_q;

  // Pick the single winning event (clear > load > shr > shl) and form the next state.
  always_comb begin
    apply     = 1'b0;
    op_nxt    = op_q;
    data_nxt  = data_q;
    trace_nxt = trace_q;
    cnt_nxt   = shift_cnt;
    if (ev_clr) begin
      apply     = 1'b1;
      op_nxt    = OP_CLR;
      data_nxt  = '0;
      trace_nxt = '0;
      cnt_nxt   = '0;
    end else if (en) begin
      if (ev_load) begin
        apply    = 1'b1;
        op_nxt   = OP_LOAD;
        data_nxt = din;
        cnt_nxt  = '0;
      end else if (ev_shr) begin
        apply     = 1'b1;
        op_nxt    = OP_SHR;
        data_nxt  = {ser_in, data_q[WIDTH-1:1]};
        trace_nxt = {data_q[0], trace_q[WIDTH-1:1]};
        cnt_nxt   = cnt_inc;
      end else if (ev_shl) begin
        apply     = 1'b1;
        op_nxt    = OP_SHL;
        data_nxt  = {data_q[WIDTH-2:0], ser_in};
        trace_nxt = {trace_q[WIDTH-2:0], data_q[WIDTH-1]};
        cnt_nxt   = cnt_inc;
      end
    end
  end

  // Commit the applied operation and pulse op_valid for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      trace_q   <= '0;
      shift_cnt <= '0;
      op_valid  <= 1'b0;
      op_q      <= OP_CLR;
    end else begin
      op_valid <= apply;
      if (apply) begin
        data_q    <= data_nxt;
        trace_q   <= trace_nxt;
        shift_cnt <= cnt_nxt;
        op_q      <= op_nxt;
      end
    end
  end

endmodule

// File: doc/key_shift_reg.md
Name: key_shift_reg

Overview:
- Parametrised front-panel shift/load register driven by four push-buttons plus a serial/parallel switch bank.
- Each button passes through a synchroniser, a debouncer and a press-edge detector, giving a one-cycle event.
- Events clear, load, shift right or shift left a WIDTH-bit data register.
- Bits shifted out are captured in a trace register. Both registers drive board LEDs.

Parameters:
- WIDTH, 8, data/trace register width (>=2)
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronised samples needed to accept a key level change (>=1)
- KEY_ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed; 0 = reads 1 when pressed

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_clr  in  1  raw button: clear
- key_load  in  1  raw button: parallel load
- key_shr  in  1  raw button: shift right
- key_shl  in  1  raw button: shift left
- en  in  1  level enable for load/shift (switch); does not gate clear
- din  in  WIDTH  parallel load value (switches)
- ser_in  in  1  serial input bit (switch)
- data_q  out  WIDTH  data register
- trace_q  out  WIDTH  shifted-out-bit history
- shift_cnt  out  $clog2(WIDTH+1)  shifts since last clear/load, saturating at WIDTH
- full  out  1  shift_cnt == WIDTH
- op_valid  out  1  one-cycle pulse when an operation is applied
- last_op  out  2  code of last applied operation

Behaviour:
- Reset (rst_n=0, async): data_q=0, trace_q=0, shift_cnt=0, full=0, op_valid=0, last_op=OP_CLR. All sync/debounce state goes to the released level, and the debounce counter goes to 0.
- Per key:
  - 2-flop synchroniser.
  - Debouncer: while the synchronised level differs from the debounced level, increment the counter. If the level agrees, zero the counter. When the counter reaches DEBOUNCE_CYCLES, update the debounced level and zero the counter.
  - Event: one-cycle pulse on a debounced released->pressed transition. Release produces no event.
  - Glitches shorter than DEBOUNCE_CYCLES samples produce no event.
- Latency: data_q/trace_q/op_valid change on the clock edge after the event pulse. The first effect is visible DEBOUNCE_CYCLES+3 edges after the first edge that samples the raw press.
- Priority when events coincide in the same cycle: clear > load > shift right > shift left. Only the winner is applied; the others are dropped, not queued.
- en=0: load/shr/shl events are dropped with no op_valid. Clear always applies.
- Clear: data_q=0, trace_q=0, shift_cnt=0.
- Load: data_q=din, shift_cnt=0, trace_q unchanged.
- Shift right: data_q={ser_in, data_q[WIDTH-1:1]}, trace_q={data_q[0], trace_q[WIDTH-1:1]}.
- Shift left: data_q={data_q[WIDTH-2:0], ser_in}, trace_q={trace_q[WIDTH-2:0], data_q[WIDTH-1]}.
- Both shifts set shift_cnt=min(shift_cnt+1, WIDTH). Shifting continues normally when full; only the count saturates.
- full is combinational from shift_cnt.
- op_valid is registered, high exactly one cycle per applied op. last_op is updated on the same edge and holds until the next applied op.
- ser_in and din are sampled in the applying cycle; they are unsynchronised switches and are assumed quasi-static.
- Reset mid-debounce discards the pending key change. A key held through reset release generates an event after DEBOUNCE_CYCLES samples.

Decomposition:
- Package key_pkg: op codes OP_CLR=2'd0, OP_LOAD=2'd1, OP_SHR=2'd2, OP_SHL=2'd3.
- Sub-module key_debounce (params DEBOUNCE_CYCLES, KEY_ACTIVE_LOW; ports clk, rst_n, key_raw, press). It holds the synchroniser, counter and edge detector, and is instantiated four times.
- Priority/datapath logic stays in key_shift_reg.

Test Plan (WIDTH=8, DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1):
- Reset, en=1, din=8'hA5, press key_load 10 cycles -> data_q=8'hA5 at edge 7 after first sampled press; op_valid one cycle; last_op=1; shift_cnt=0.
- From 8'hA5: ser_in=1, three key_shr presses -> data_q 8'hD2, 8'hE9, 8'hF4; trace_q 8'h80, 8'h40, 8'hA0; shift_cnt=3.
- From 8'h81 after load: ser_in=0, nine key_shl presses -> data_q=8'h00, trace_q=8'h02, shift_cnt saturates 8, full=1 from the 8th press.
- key_load held low for 3 cycles (glitch) -> no op_valid, data_q unchanged. en=0 with key_shr press -> dropped. en=0 with key_clr -> data_q=0, trace_q=0.
- key_clr and key_load pressed on the same cycle -> single op_valid, last_op=0, data_q=0. Assert rst_n mid-debounce of key_shr -> all outputs reset, no later event while key stays released.
